// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with per-register pending-write scoreboard, NZP condition codes and BEN latch.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle writeback data and busy onto the read ports.
module lc3_regfile_sb #(
    parameter  int WIDTH    = 16,
    parameter  int NREGS    = 8,
    parameter  int PEND_MAX = 3,
    localparam int AW       = $clog2(NREGS),
    localparam int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Issue_Valid,
    input  logic [AW-1:0]    Issue_DR,
    output logic             Issue_Ready,
    input  logic [AW-1:0]    Rd1_Addr,
    output logic [WIDTH-1:0] Rd1_Data,
    output logic             Rd1_Busy,
    input  logic [AW-1:0]    Rd2_Addr,
    output logic [WIDTH-1:0] Rd2_Data,
    output logic             Rd2_Busy,
    input  logic             Wb_Valid,
    input  logic [AW-1:0]    Wb_Addr,
    input  logic [WIDTH-1:0] Wb_Data,
    input  logic             Wb_Ld_CC,
    input  logic             Ld_BEN,
    input  logic [2:0]       Br_Cond,
    output logic [2:0]       NZP,
    output logic             BEN,
    output logic             Wb_Err
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [PW-1:0]    cnt_q  [NREGS];
    logic [PW-1:0]    cnt_d  [NREGS];
    logic [2:0]       nzp_q, nzp_d;
    logic             ben_q, ben_d;
    logic             err_q, err_d;
    logic             issue_acc;
    logic             underflow;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;

    // A full register may still accept an issue when a writeback retires one slot in the same cycle.
    always_comb begin
        Issue_Ready = !Issue_Valid
                      || (cnt_q[Issue_DR] < PW'(PEND_MAX))
                      || (Wb_Valid && (Wb_Addr == Issue_DR));
        issue_acc   = Issue_Valid && Issue_Ready;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc_vec[r] = issue_acc && (Issue_DR == AW'(r));
            dec_vec[r] = Wb_Valid && (Wb_Addr == AW'(r));
        end
    end

    always_comb begin
        underflow = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + PW'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) begin
                    underflow = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - PW'(1);
                end
            end
        end
    end

    always_comb begin
        nzp_d = nzp_q;
        if (Wb_Valid && Wb_Ld_CC) begin
            if (Wb_Data[WIDTH-1]) begin
                nzp_d = 3'b100;
            end else if (Wb_Data == '0) begin
                nzp_d = 3'b010;
            end else begin
                nzp_d = 3'b001;
            end
        end
        // BEN sees the codes as they stand before this edge, never a same-cycle load.
        ben_d = Ld_BEN ? |(nzp_q & Br_Cond) : ben_q;
        err_d = err_q | underflow;
    end

    always_comb begin
        Rd1_Data = regs_q[Rd1_Addr];
        Rd1_Busy = (cnt_q[Rd1_Addr] != '0);
        if (BYPASS && Wb_Valid && (Wb_Addr == Rd1_Addr)) begin
            Rd1_Data = Wb_Data;
            Rd1_Busy = (cnt_d[Rd1_Addr] != '0);
        end
    end

    always_comb begin
        Rd2_Data = regs_q[Rd2_Addr];
        Rd2_Busy = (cnt_q[Rd2_Addr] != '0);
        if (BYPASS && Wb_Valid && (Wb_Addr == Rd2_Addr)) begin
            Rd2_Data = Wb_Data;
            Rd2_Busy = (cnt_d[Rd2_Addr] != '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            nzp_q <= 3'b000;
            ben_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (Wb_Valid) begin
                regs_q[Wb_Addr] <= Wb_Data;
            end
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            nzp_q <= nzp_d;
            ben_q <= ben_d;
            err_q <= err_d;
        end
    end

    assign NZP    = nzp_q;
    assign BEN    = ben_q;
    assign Wb_Err = err_q;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Scoreboard bench for lc3_regfile_sb: stimulus queues expected outputs, a negedge monitor compares.
// Expectations for the same-cycle read path follow REGFILE_BYPASS_EN when it is defined.
module tb_lc3_regfile_sb;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    localparam int S_READY = 0, S_RD1D = 1, S_RD1B = 2, S_RD2D = 3, S_RD2B = 4,
                   S_NZP = 5, S_BEN = 6, S_ERR = 7;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Issue_Valid;
    logic [AW-1:0]    Issue_DR;
    logic             Issue_Ready;
    logic [AW-1:0]    Rd1_Addr, Rd2_Addr;
    logic [WIDTH-1:0] Rd1_Data, Rd2_Data;
    logic             Rd1_Busy, Rd2_Busy;
    logic             Wb_Valid;
    logic [AW-1:0]    Wb_Addr;
    logic [WIDTH-1:0] Wb_Data;
    logic             Wb_Ld_CC, Ld_BEN;
    logic [2:0]       Br_Cond;
    logic [2:0]       NZP;
    logic             BEN, Wb_Err;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    lc3_regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .PEND_MAX(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .Issue_Valid(Issue_Valid), .Issue_DR(Issue_DR), .Issue_Ready(Issue_Ready),
        .Rd1_Addr(Rd1_Addr), .Rd1_Data(Rd1_Data), .Rd1_Busy(Rd1_Busy),
        .Rd2_Addr(Rd2_Addr), .Rd2_Data(Rd2_Data), .Rd2_Busy(Rd2_Busy),
        .Wb_Valid(Wb_Valid), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data), .Wb_Ld_CC(Wb_Ld_CC),
        .Ld_BEN(Ld_BEN), .Br_Cond(Br_Cond), .NZP(NZP), .BEN(BEN), .Wb_Err(Wb_Err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            S_READY: return 32'(Issue_Ready);
            S_RD1D:  return 32'(Rd1_Data);
            S_RD1B:  return 32'(Rd1_Busy);
            S_RD2D:  return 32'(Rd2_Data);
            S_RD2B:  return 32'(Rd2_Busy);
            S_NZP:   return 32'(NZP);
            S_BEN:   return 32'(BEN);
            default: return 32'(Wb_Err);
        endcase
    endfunction

    always @(negedge Clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h at %0t", e.name, a, e.exp, $time);
            end
        end
    end

    task automatic expect_v(string name, int sel, logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset       = 1'b0;
        Issue_Valid = 1'b0;
        Issue_DR    = '0;
        Wb_Valid    = 1'b0;
        Wb_Addr     = '0;
        Wb_Data     = '0;
        Wb_Ld_CC    = 1'b0;
        Ld_BEN      = 1'b0;
        Br_Cond     = 3'b000;
    endtask

    task automatic wb(logic [AW-1:0] a, logic [WIDTH-1:0] d, logic cc);
        Wb_Valid = 1'b1;
        Wb_Addr  = a;
        Wb_Data  = d;
        Wb_Ld_CC = cc;
    endtask

    task automatic issue(logic [AW-1:0] a);
        Issue_Valid = 1'b1;
        Issue_DR    = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        Rd1_Addr = '0;
        Rd2_Addr = '0;
        Reset    = 1'b1;
        step();
        step();
        idle();

        expect_v("rst_nzp", S_NZP, 0);
        expect_v("rst_ben", S_BEN, 0);
        expect_v("rst_err", S_ERR, 0);
        expect_v("rst_ready", S_READY, 1);
        for (int r = 0; r < NREGS; r++) begin
            Rd1_Addr = AW'(r);
            Rd2_Addr = AW'(NREGS - 1 - r);
            expect_v("rst_rd1_data", S_RD1D, 0);
            expect_v("rst_rd1_busy", S_RD1B, 0);
            expect_v("rst_rd2_data", S_RD2D, 0);
            expect_v("rst_rd2_busy", S_RD2B, 0);
            step();
        end

        // Fill R3 to the pending limit.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(3);
            expect_v("fill_ready", S_READY, 1);
            step();
        end
        idle(); issue(3); Rd1_Addr = 3;
        expect_v("full_ready", S_READY, 0);
        expect_v("full_busy", S_RD1B, 1);
        step();
        idle(); issue(3); wb(3, 16'h1234, 1'b0);
        expect_v("full_wb_ready", S_READY, 1);
        step();
        idle(); issue(3); Rd1_Addr = 3;
        expect_v("still_full_ready", S_READY, 0);
        expect_v("r3_data", S_RD1D, 16'h1234);
        expect_v("r3_busy", S_RD1B, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(); wb(3, 16'h1234, 1'b0);
            step();
        end
        idle(); Rd1_Addr = 3;
        expect_v("drain_busy", S_RD1B, 0);
        expect_v("drain_err", S_ERR, 0);
        step();

        // Condition codes and BEN.
        idle(); issue(5); wb(5, 16'h8000, 1'b1);
        expect_v("cc_ready", S_READY, 1);
        step();
        idle(); Rd2_Addr = 5; Ld_BEN = 1'b1; Br_Cond = 3'b100;
        expect_v("nzp_neg", S_NZP, 3'b100);
        expect_v("r5_data", S_RD2D, 16'h8000);
        expect_v("r5_busy", S_RD2B, 0);
        expect_v("sameissue_err", S_ERR, 0);
        step();
        idle(); Ld_BEN = 1'b1; Br_Cond = 3'b011;
        expect_v("ben_n", S_BEN, 1);
        step();
        idle();
        expect_v("ben_zp", S_BEN, 0);
        step();
        idle(); issue(6); wb(6, 16'h0005, 1'b1);
        step();
        idle(); issue(6); wb(6, 16'h0000, 1'b1); Ld_BEN = 1'b1; Br_Cond = 3'b010;
        expect_v("nzp_pos", S_NZP, 3'b001);
        step();
        idle(); Wb_Ld_CC = 1'b1; Wb_Data = 16'h8000;
        expect_v("ben_old_nzp", S_BEN, 0);
        expect_v("nzp_zero", S_NZP, 3'b010);
        step();
        idle();
        expect_v("cc_no_valid", S_NZP, 3'b010);
        expect_v("cc_err", S_ERR, 0);
        step();

        // Writeback with nothing pending.
        idle(); wb(2, 16'hBEEF, 1'b0);
        step();
        idle(); Rd1_Addr = 2;
        expect_v("r2_data", S_RD1D, 16'hBEEF);
        expect_v("r2_busy", S_RD1B, 0);
        expect_v("err_set", S_ERR, 1);
        step();
        idle(); Ld_BEN = 1'b1; Br_Cond = 3'b111;
        expect_v("err_sticky", S_ERR, 1);
        step();
        idle();
        expect_v("ben_z", S_BEN, 1);
        step();

        // Read during retiring writeback.
        idle(); issue(1);
        step();
        idle(); Rd1_Addr = 1; Rd2_Addr = 1;
        expect_v("r1_pend_busy", S_RD1B, 1);
        expect_v("r1_pend_data", S_RD1D, 0);
        step();
        idle(); wb(1, 16'h00FF, 1'b0); Rd1_Addr = 1; Rd2_Addr = 1;
        expect_v("byp_rd1_data", S_RD1D, BYP ? 32'h00FF : 32'h0);
        expect_v("byp_rd1_busy", S_RD1B, BYP ? 32'h0 : 32'h1);
        expect_v("byp_rd2_data", S_RD2D, BYP ? 32'h00FF : 32'h0);
        expect_v("byp_rd2_busy", S_RD2B, BYP ? 32'h0 : 32'h1);
        step();
        idle(); Rd1_Addr = 1;
        expect_v("r1_after_data", S_RD1D, 16'h00FF);
        expect_v("r1_after_busy", S_RD1B, 0);
        step();

        // Reset overrides a simultaneous issue and writeback.
        idle(); Reset = 1'b1; issue(4); wb(4, 16'h1111, 1'b1);
        step();
        idle(); Rd1_Addr = 4; Rd2_Addr = 1;
        expect_v("rst2_r4_data", S_RD1D, 0);
        expect_v("rst2_r4_busy", S_RD1B, 0);
        expect_v("rst2_r1_data", S_RD2D, 0);
        expect_v("rst2_nzp", S_NZP, 0);
        expect_v("rst2_ben", S_BEN, 0);
        expect_v("rst2_err", S_ERR, 0);
        step();
        idle();
        step();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
